// File: rtl/write_fifo_buff_pkg.sv
// -----------------------------------------------------------------------------
// write_fifo_buff_pkg
//   Shared UART buffer definitions. The RX buffer reuses the default data
//   width and FIFO sizing, so these values live here and not in the FIFO.
//
//   Contents:
//     UART_DATA_WIDTH       default payload width (one UART character)
//     FIFO_DEPTH_DEFAULT    default number of queued words
//     FIFO_AF_LEVEL_DEFAULT default almost-full threshold
//     fifo_op_t             per-cycle operation decode (push / pop / flush)
//     ptr_width()           pointer width for a given depth (one extra wrap bit)
// -----------------------------------------------------------------------------
package write_fifo_buff_pkg;

    localparam int UART_DATA_WIDTH       = 8;
    localparam int FIFO_DEPTH_DEFAULT    = 8;
    localparam int FIFO_AF_LEVEL_DEFAULT = 6;

    // Operations that can occur on one clock edge.
    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } fifo_op_t;

    // Pointers carry one bit beyond the address. That bit separates the
    // full condition from the empty condition when the low bits are equal.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/write_fifo_buff_mem.sv
// -----------------------------------------------------------------------------
// write_fifo_buff_mem
//   DEPTH x DATA_WIDTH register array used as FIFO storage.
//   Each entry has its own write enable and is never reset. The read port
//   is combinational so the FIFO head appears with first-word fall-through.
//
//   Ports:
//     clk      in   1            system clock, rising edge
//     wr_en    in   1            write wr_data into entry wr_addr
//     wr_addr  in   ADDR_W       write address
//     wr_data  in   DATA_WIDTH   write data
//     rd_addr  in   ADDR_W       read address
//     rd_data  out  DATA_WIDTH   entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module write_fifo_buff_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] entry_word [DEPTH];

    // Each entry is its own register. That keeps every storage element
    // driven by exactly one process.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_word[gi] = entry_reg;
        end
    endgenerate

    assign rd_data = entry_word[rd_addr];

endmodule

// File: rtl/write_fifo_buff.sv
// -----------------------------------------------------------------------------
// write_fifo_buff
//   Multi-entry write buffer between the host write path and the UART TX
//   serializer. It queues up to DEPTH words and uses valid/ready on both
//   sides. The head word falls through to data_o. Push and pop can occur in
//   the same cycle for full throughput.
//
//   Ports:
//     clk          in   1             system clock, rising edge
//     rstn         in   1             asynchronous active-low reset
//     flush        in   1             synchronous clear of all entries
//     data_i       in   DATA_WIDTH    write data
//     valid_in     in   1             write request
//     ready_in     out  1             buffer can accept a word (not full)
//     data_o       out  DATA_WIDTH    head-of-queue data
//     valid_out    out  1             head valid (not empty)
//     ready_out    in   1             TX serializer accepts the head word
//     start        out  1             one pulse per word popped
//     count        out  ADDR_W+1      occupancy, 0..DEPTH
//     almost_full  out  1             count >= AF_LEVEL
// -----------------------------------------------------------------------------
module write_fifo_buff
    import write_fifo_buff_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH_DEFAULT,     // power of 2, >= 2
    parameter int AF_LEVEL   = FIFO_AF_LEVEL_DEFAULT   // 1..DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_in,
    output logic                   ready_in,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic                   start,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);
    // XOR of the two pointers when the buffer is full: wrap bits differ and
    // the address bits are equal.
    localparam logic [PTR_W-1:0] FULL_XOR  = {1'b1, {ADDR_W{1'b0}}};

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] count_reg,  count_next;

    logic     empty;
    logic     full;
    fifo_op_t op;

    // ------------------------------------------------------------------
    // Flag decode. Only registered pointers feed these flags, so no
    // combinational path runs from valid_in to ready_in.
    // ------------------------------------------------------------------
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);

    assign ready_in    = ~full;
    assign valid_out   = ~empty;
    assign almost_full = (count_reg >= AF_THRESH);
    assign count       = count_reg;

    // While full, ready_in is low even if a pop happens this cycle. The
    // freed slot becomes writable on the next cycle.
    assign op.push  = valid_in  & ~full;
    assign op.pop   = ready_out & ~empty;
    assign op.flush = flush;

    // The handshake completes during a flush too, so start still pulses.
    assign start = op.pop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (op.flush) begin
            // Flush takes priority over any push or pop this cycle.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (op.push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (op.pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({op.push, op.pop})
                2'b10:   count_next = count_reg + PTR_ONE;
                2'b01:   count_next = count_reg - PTR_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage. A flushed push is dropped, so the write is gated as well.
    // ------------------------------------------------------------------
    write_fifo_buff_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (op.push & ~op.flush),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (data_i),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (data_o)
    );

endmodule

// File: tb/tb_write_fifo_buff.sv
// -----------------------------------------------------------------------------
// tb_write_fifo_buff
//   Self-checking bench for write_fifo_buff (DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6).
//   Stimulus is applied 1 ns after the rising edge. Outputs are compared on
//   the falling edge. The reference is a queue of words updated once per edge.
// -----------------------------------------------------------------------------
module tb_write_fifo_buff;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush;
    logic [DW-1:0] data_i;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_o;
    logic          valid_out;
    logic          ready_out;
    logic          start;
    logic [3:0]    count;
    logic          almost_full;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];

    always #5 clk = ~clk;

    write_fifo_buff #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .data_i      (data_i),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_o      (data_o),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .start       (start),
        .count       (count),
        .almost_full (almost_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_model(input string tag);
        int sz = model_q.size();
        chk({tag, ".count"},       32'(count),       32'(sz));
        chk({tag, ".ready_in"},    32'(ready_in),    32'(sz < DEPTH));
        chk({tag, ".valid_out"},   32'(valid_out),   32'(sz > 0));
        chk({tag, ".start"},       32'(start),       32'(ready_out && sz > 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF));
        if (sz > 0) chk({tag, ".data_o"}, 32'(data_o), 32'(model_q[0]));
    endtask

    // One clock cycle: drive inputs, check on the falling edge, take the
    // edge, then update the model. Pop and push are decided from the
    // occupancy before the edge.
    task automatic run_cycle(input string tag, input logic vi, input logic [DW-1:0] d,
                             input logic ro, input logic fl);
        bit do_push, do_pop;
        valid_in  = vi;
        data_i    = d;
        ready_out = ro;
        flush     = fl;
        #4;
        check_model(tag);
        do_push = vi && (model_q.size() < DEPTH);
        do_pop  = ro && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        $display("cycle %-8s vi=%0b d=%02h ro=%0b fl=%0b -> occupancy %0d", tag, vi, d, ro, fl, model_q.size());
        #1;
    endtask

    // Table-driven vectors with hand-derived expectations.
    typedef struct {
        logic          vi;
        logic [DW-1:0] d;
        logic          ro;
        logic [3:0]    cnt;
        logic          rin;
        logic          vout;
        logic          dchk;
        logic [DW-1:0] dexp;
        logic          st;
        logic          af;
    } vec_t;

    function automatic vec_t mk(logic vi, logic [DW-1:0] d, logic ro, logic [3:0] cnt,
                                logic rin, logic vout, logic dchk, logic [DW-1:0] dexp,
                                logic st, logic af);
        vec_t v;
        v.vi = vi; v.d = d; v.ro = ro; v.cnt = cnt; v.rin = rin; v.vout = vout;
        v.dchk = dchk; v.dexp = dexp; v.st = st; v.af = af;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        // Fill 0x01..0x08 while the sink stalls.
        vecs[0]  = mk(1, 8'h01, 0, 4'd0, 1, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 8'h02, 0, 4'd1, 1, 1, 1, 8'h01, 0, 0);
        vecs[2]  = mk(1, 8'h03, 0, 4'd2, 1, 1, 1, 8'h01, 0, 0);
        vecs[3]  = mk(1, 8'h04, 0, 4'd3, 1, 1, 1, 8'h01, 0, 0);
        vecs[4]  = mk(1, 8'h05, 0, 4'd4, 1, 1, 1, 8'h01, 0, 0);
        vecs[5]  = mk(1, 8'h06, 0, 4'd5, 1, 1, 1, 8'h01, 0, 0);
        vecs[6]  = mk(1, 8'h07, 0, 4'd6, 1, 1, 1, 8'h01, 0, 1);
        vecs[7]  = mk(1, 8'h08, 0, 4'd7, 1, 1, 1, 8'h01, 0, 1);
        // The ninth write is refused while full.
        vecs[8]  = mk(1, 8'h09, 0, 4'd8, 0, 1, 1, 8'h01, 0, 1);
        // Full with ready_out=1: pop only, and 0x0A is not accepted.
        vecs[9]  = mk(1, 8'h0A, 1, 4'd8, 0, 1, 1, 8'h01, 1, 1);
        // Drain. The order must be 0x02..0x08.
        vecs[10] = mk(0, 8'h00, 1, 4'd7, 1, 1, 1, 8'h02, 1, 1);
        vecs[11] = mk(0, 8'h00, 1, 4'd6, 1, 1, 1, 8'h03, 1, 1);
        vecs[12] = mk(0, 8'h00, 1, 4'd5, 1, 1, 1, 8'h04, 1, 0);
        vecs[13] = mk(0, 8'h00, 1, 4'd4, 1, 1, 1, 8'h05, 1, 0);
        vecs[14] = mk(0, 8'h00, 1, 4'd3, 1, 1, 1, 8'h06, 1, 0);
        vecs[15] = mk(0, 8'h00, 1, 4'd2, 1, 1, 1, 8'h07, 1, 0);
        vecs[16] = mk(0, 8'h00, 1, 4'd1, 1, 1, 1, 8'h08, 1, 0);
        vecs[17] = mk(0, 8'h00, 1, 4'd0, 1, 0, 0, 8'h00, 0, 0);

        rstn = 1'b0; flush = 1'b0; data_i = '0; valid_in = 1'b0; ready_out = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.count",       32'(count),       32'd0);
        chk("rst.ready_in",    32'(ready_in),    32'd1);
        chk("rst.valid_out",   32'(valid_out),   32'd0);
        chk("rst.almost_full", 32'(almost_full), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // ---- table-driven fill / full / drain ----
        for (int i = 0; i < 18; i++) begin
            valid_in = vecs[i].vi; data_i = vecs[i].d; ready_out = vecs[i].ro; flush = 1'b0;
            #4;
            chk($sformatf("vec%0d.count", i),       32'(count),       32'(vecs[i].cnt));
            chk($sformatf("vec%0d.ready_in", i),    32'(ready_in),    32'(vecs[i].rin));
            chk($sformatf("vec%0d.valid_out", i),   32'(valid_out),   32'(vecs[i].vout));
            chk($sformatf("vec%0d.start", i),       32'(start),       32'(vecs[i].st));
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            if (vecs[i].dchk) chk($sformatf("vec%0d.data_o", i), 32'(data_o), 32'(vecs[i].dexp));
            @(posedge clk);
            $display("vector %0d vi=%0b d=%02h ro=%0b count=%0d", i, vecs[i].vi, vecs[i].d, vecs[i].ro, count);
            #1;
        end
        // The table ends with the buffer empty, which is also the model's state.

        // ---- streaming with count=3; pointers wrap several times ----
        for (int i = 0; i < 3; i++) run_cycle("prime", 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            run_cycle("stream", 1, 8'(8'h20 + i), 1, 0);
            chk("stream.count3", 32'(count), 32'd3);
        end

        // ---- flush with count=5 and a simultaneous push/pop ----
        run_cycle("fill5", 1, 8'h31, 0, 0);
        run_cycle("fill5", 1, 8'h32, 0, 0);
        run_cycle("flush", 1, 8'hAA, 1, 1);
        chk("flush.count",     32'(count),     32'd0);
        chk("flush.valid_out", 32'(valid_out), 32'd0);
        run_cycle("postfl", 0, 8'h00, 1, 0);
        run_cycle("postfl", 1, 8'h5C, 0, 0);
        chk("postfl.data_o", 32'(data_o), 32'h5C);
        run_cycle("postfl", 0, 8'h00, 1, 0);
        run_cycle("postfl", 0, 8'h00, 1, 0);

        // ---- asynchronous reset mid-stream ----
        for (int i = 0; i < 7; i++) run_cycle("prerst", 1, 8'(8'h40 + i), 0, 0);
        valid_in = 1'b1; ready_out = 1'b1;
        rstn = 1'b0;
        #1;
        chk("arst.count",       32'(count),       32'd0);
        chk("arst.ready_in",    32'(ready_in),    32'd1);
        chk("arst.valid_out",   32'(valid_out),   32'd0);
        chk("arst.start",       32'(start),       32'd0);
        chk("arst.almost_full", 32'(almost_full), 32'd0);
        $display("async reset asserted mid-stream at %0t", $time);
        #2;
        rstn = 1'b1;
        model_q.delete();
        run_cycle("postrst", 0, 8'h00, 1, 0);

        // ---- randomized: a filling phase, then a draining phase ----
        for (int i = 0; i < 300; i++) begin
            logic vi, ro, fl;
            logic [DW-1:0] d;
            vi = ($urandom_range(99) < 75);
            ro = (i < 150) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 80);
            fl = ($urandom_range(99) < 4);
            d  = 8'($urandom);
            run_cycle("rand", vi, d, ro, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
